// File: rtl/dac_sample_sequencer.sv
// Paces samples from a small FIFO onto the avsddac D input at a programmable rate.
// Handles priming before playback, underrun counting, and a clean stop to the idle code.
module dac_sample_sequencer #(
   parameter int unsigned   DW          = 10,
   parameter int unsigned   DEPTH       = 4,
   parameter int unsigned   DIV_W       = 16,
   parameter int unsigned   PRIME_LEVEL = 2,
   parameter logic [DW-1:0] IDLE_CODE   = 10'd512
) (
   input  logic                     CLK,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic [DIV_W-1:0]         div,
   input  logic [DW-1:0]            in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [DW-1:0]            D,
   output logic                     sample_strobe,
   output logic                     underrun,
   output logic [7:0]               underrun_cnt,
   input  logic                     clear_underrun,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     busy
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [LW-1:0] LvlFull  = LW'(DEPTH);
   localparam logic [LW-1:0] LvlPrime = LW'(PRIME_LEVEL);

   typedef enum logic [1:0] {StIdle, StPrime, StRun, StStop} state_e;

   state_e           state_q, state_d;
   logic [DW-1:0]    mem [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [LW-1:0]    level_q, level_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DW-1:0]    d_q, d_d;
   logic [7:0]       ucnt_q;
   logic             tick, push, pop, flush;

   always_comb begin
      tick          = ((state_q == StRun) || (state_q == StStop)) && (cnt_q == '0);
      in_ready      = ((state_q == StPrime) || (state_q == StRun)) && (level_q != LvlFull);
      push          = in_valid && in_ready;
      pop           = (state_q == StRun) && tick && (level_q != '0);
      underrun      = (state_q == StRun) && tick && (level_q == '0);
      sample_strobe = pop;

      state_d = state_q;
      d_d     = d_q;
      flush   = 1'b0;
      cnt_d   = cnt_q;
      if (tick) begin
         cnt_d = div;
      end else if ((state_q == StRun) || (state_q == StStop)) begin
         cnt_d = cnt_q - DIV_W'(1);
      end

      unique case (state_q)
         StIdle: begin
            flush = 1'b1;
            d_d   = IDLE_CODE;
            if (enable) state_d = StPrime;
         end
         StPrime: begin
            if (!enable) begin
               state_d = StIdle;
               flush   = 1'b1;
            end else if (level_q >= LvlPrime) begin
               state_d = StRun;
               cnt_d   = div;
            end
         end
         StRun: begin
            if (pop) d_d = mem[rptr_q];
            if (!enable) state_d = StStop;
         end
         StStop: begin
            // Finish the current period before returning to the idle code.
            if (tick) begin
               d_d     = IDLE_CODE;
               flush   = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (flush) begin
         level_d = '0;
      end else begin
         level_d = level_q + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         d_q     <= IDLE_CODE;
         cnt_q   <= '0;
         level_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         ucnt_q  <= '0;
      end else begin
         state_q <= state_d;
         d_q     <= d_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         if (flush) begin
            wptr_q <= '0;
            rptr_q <= '0;
         end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
         end
         if (clear_underrun) begin
            ucnt_q <= '0;
         end else if (underrun && (ucnt_q != 8'hFF)) begin
            ucnt_q <= ucnt_q + 8'd1;
         end
      end
   end

   // Storage needs no reset; occupancy is governed by level_q and the pointers.
   always_ff @(posedge CLK) begin
      if (push) mem[wptr_q] <= in_data;
   end

   assign D            = d_q;
   assign fifo_level   = level_q;
   assign underrun_cnt = ucnt_q;
   assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_dac_sample_sequencer.sv
// Randomized bench for dac_sample_sequencer: a queue-based reference model predicts every
// cycle, and a strobe-driven monitor checks each played sample against a scoreboard.
module tb_dac_sample_sequencer;

   localparam int DEPTH = 4;
   localparam int IDLE  = 512;

   logic        CLK = 1'b0;
   logic        reset_n = 1'b0;
   logic        enable = 1'b0;
   logic [15:0] div = 16'd3;
   logic [9:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [9:0]  D;
   logic        sample_strobe;
   logic        underrun;
   logic [7:0]  underrun_cnt;
   logic        clear_underrun = 1'b0;
   logic [2:0]  fifo_level;
   logic        busy;

   dac_sample_sequencer dut (
      .CLK            (CLK),
      .reset_n        (reset_n),
      .enable         (enable),
      .div            (div),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .D              (D),
      .sample_strobe  (sample_strobe),
      .underrun       (underrun),
      .underrun_cnt   (underrun_cnt),
      .clear_underrun (clear_underrun),
      .fifo_level     (fifo_level),
      .busy           (busy)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: 0 idle, 1 priming, 2 playing, 3 stopping.
   int mphase;
   int mleft;          // cycles remaining before the next tick
   int md;
   int mucnt;
   int fm[$];          // queued samples
   int exp_q[$];       // samples expected on D, in play order
   bit sb_pend = 1'b0;

   function automatic bit m_ready();
      return ((mphase == 1) || (mphase == 2)) && (fm.size() < DEPTH);
   endfunction
   function automatic bit m_tick();
      return (mphase >= 2) && (mleft == 0);
   endfunction
   function automatic bit m_strobe();
      return (mphase == 2) && m_tick() && (fm.size() > 0);
   endfunction
   function automatic bit m_under();
      return (mphase == 2) && m_tick() && (fm.size() == 0);
   endfunction

   bit tk, rdy, strb, und, psh;
   int lvl0;

   always @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         mphase = 0; mleft = 0; md = IDLE; mucnt = 0;
         fm.delete();
         exp_q.delete();
      end else begin
         lvl0 = fm.size();
         rdy  = m_ready();
         tk   = m_tick();
         strb = m_strobe();
         und  = m_under();
         psh  = in_valid && rdy;
         case (mphase)
            0: begin
               fm.delete();
               md = IDLE;
               if (enable) mphase = 1;
            end
            1: begin
               if (psh) fm.push_back(int'(in_data));
               if (!enable) begin
                  fm.delete();
                  mphase = 0;
               end else if (lvl0 >= 2) begin
                  mphase = 2;
                  mleft  = int'(div);
               end
            end
            2: begin
               if (strb) begin
                  md = fm.pop_front();
                  exp_q.push_back(md);
               end
               if (psh) fm.push_back(int'(in_data));
               mleft = tk ? int'(div) : mleft - 1;
               if (!enable) mphase = 3;
            end
            default: begin
               if (tk) begin
                  md = IDLE;
                  fm.delete();
                  mphase = 0;
               end else begin
                  mleft = mleft - 1;
               end
            end
         endcase
         if (clear_underrun) mucnt = 0;
         else if (und && mucnt < 255) mucnt++;
      end
   end

   // Cycle checks plus the strobe-driven scoreboard monitor.
   always @(negedge CLK) begin
      chk("in_ready", int'(in_ready), int'(m_ready()));
      chk("busy", int'(busy), int'(mphase != 0));
      chk("sample_strobe", int'(sample_strobe), int'(m_strobe()));
      chk("underrun", int'(underrun), int'(m_under()));
      chk("fifo_level", int'(fifo_level), fm.size());
      chk("D", int'(D), md);
      chk("underrun_cnt", int'(underrun_cnt), mucnt);
      if (!reset_n) sb_pend = 1'b0;
      if (sb_pend) begin
         if (exp_q.size() == 0) chk("sb_unexpected_sample", int'(D), -1);
         else chk("sb_sample", int'(D), exp_q.pop_front());
         sb_pend = 1'b0;
      end
      if (sample_strobe) sb_pend = 1'b1;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic rand_run(input int n, input int rate);
      repeat (n) begin
         @(posedge CLK);
         #1;
         in_valid       = ($urandom_range(0, 99) < rate);
         in_data        = 10'($urandom);
         clear_underrun = ($urandom_range(0, 63) == 0);
      end
      in_valid       = 1'b0;
      clear_underrun = 1'b0;
   endtask

   task automatic send(input int v);
      bit r, ok;
      ok       = 1'b0;
      in_data  = 10'(v);
      in_valid = 1'b1;
      for (int i = 0; i < 1000 && !ok; i++) begin
         @(negedge CLK);
         r = in_ready;
         @(posedge CLK);
         #1;
         ok = r;
      end
      in_valid = 1'b0;
      if (!ok) chk("send_timeout", 0, 1);
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound && busy; i++) step(1);
      chk("idle_timeout", int'(busy), 0);
   endtask

   initial begin
      step(3);
      chk("rst_D", int'(D), IDLE);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_busy", int'(busy), 0);
      reset_n = 1'b1;
      step(2);

      enable = 1'b1;
      step(1);
      chk("en_busy", int'(busy), 1);
      chk("en_in_ready", int'(in_ready), 1);

      // Basic pacing at div=3.
      div = 16'd3;
      send(10'h001);
      send(10'h002);
      send(10'h003);
      send(10'h3FF);
      step(20);
      enable = 1'b0;
      wait_idle(50);

      // Underrun and saturation at div=1.
      div = 16'd1;
      enable = 1'b1;
      send(10'h111);
      send(10'h222);
      step(700);
      chk("ucnt_saturated", int'(underrun_cnt), 255);
      clear_underrun = 1'b1;
      step(1);
      clear_underrun = 1'b0;
      chk("ucnt_cleared", int'(underrun_cnt), 0);
      enable = 1'b0;
      wait_idle(50);

      // Full FIFO under continuous valid at div=100, then stop mid-period.
      div = 16'd100;
      enable = 1'b1;
      rand_run(450, 100);
      step(37);
      enable = 1'b0;
      step(5);
      enable = 1'b1;
      step(3);
      enable = 1'b0;
      wait_idle(300);

      // Randomized sessions.
      for (int it = 0; it < 10; it++) begin
         div = 16'($urandom_range(0, 4));
         enable = 1'b1;
         rand_run(150, $urandom_range(10, 100));
         enable = 1'b0;
         rand_run(10, 50);
         wait_idle(50);
         step(2);
      end
      chk("sb_drained", exp_q.size(), 0);

      // Async reset mid-stream at div=0.
      div = 16'd0;
      enable = 1'b1;
      rand_run(40, 100);
      in_valid = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_D", int'(D), IDLE);
      chk("arst_level", int'(fifo_level), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_in_ready", int'(in_ready), 0);
      in_valid = 1'b0;
      step(2);
      reset_n = 1'b1;
      enable = 1'b0;
      step(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
